mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory port of the multi-cycle RISC-V core between two requesters:
//  instruction fetch (IF) and load/store (D). When both request in the same cycle, the winner is chosen round-robin.
//  The chosen request is latched, driven onto the memory for exactly one ACCESS cycle, and answered with a
//  registered response pulse. Sits between the core controller/datapath and the memory.
// PARAMETERS
//  ADDR_W  32  byte-address width on requester and memory sides
//  DATA_W  32  word width of read/write data
// PORTS
//  clk             in   1       system clock; all state changes on posedge
//  rst             in   1       asynchronous, active-high reset
//  if_req          in   1       fetch request; held until if_gnt
//  if_addr         in   ADDR_W  fetch byte address
//  if_gnt          out  1       fetch request accepted (comb, this cycle)
//  if_rvalid       out  1       one-cycle pulse; if_rdata valid
//  if_rdata        out  DATA_W  fetched instruction word
//  d_req           in   1       load/store request; held until d_gnt
//  d_we            in   1       1 = store, 0 = load
//  d_addr          in   ADDR_W  data byte address
//  d_wdata         in   DATA_W  store data
//  d_gnt           out  1       data request accepted (comb, this cycle)
//  d_rvalid        out  1       one-cycle pulse; load data valid / store done
//  d_rdata         out  DATA_W  load data
//  mem_adr         out  ADDR_W  memory address (latched request address)
//  mem_write_data  out  DATA_W  memory write data
//  mem_write       out  1       memory write enable; high only in ACCESS with a latched store
//  mem_read_data   in   DATA_W  combinational memory read data
// BEHAVIOUR
//  Reset: state=IDLE; last_served=D, so fetch wins the first tie.
//   All outputs 0: gnt, rvalid, rdata, mem_*. mem_write drops immediately on rst (async).
//  States:
//   IDLE: arbitrate.
//   ACCESS: drive memory for one cycle.
//   RESP: pulse rvalid for the owner; arbitrate again.
//  Arbitration (IDLE or RESP):
//   Only one req high -> grant it.
//   Both high -> grant the one != last_served.
//   Grant = comb gnt pulse this cycle; latch addr/wdata/we/owner; last_served<=owner; next state ACCESS.
//   No req -> IDLE.
//  ACCESS:
//   mem_adr/mem_write_data come from the latch.
//   mem_write = latched we (owner D only; IF never writes).
//   Load/fetch: mem_read_data is captured into the owner's rdata register at the closing edge.
//   Next state is RESP unconditionally.
//  RESP: owner's rvalid=1 for exactly this cycle; the other requester's rvalid=0.
//   Store response: d_rvalid pulses; d_rdata holds its previous value.
//  Latency: req seen in cycle N -> gnt in N -> ACCESS in N+1 -> rvalid in N+2.
//   Best throughput: one access per 2 cycles (RESP overlaps the next grant).
//  gnt never fires in ACCESS. A req held through ACCESS is arbitrated in RESP.
//  Starvation bound: with both requesters continuously requesting, grants strictly alternate IF, D, IF, D...
//  Inputs sampled only in the grant cycle; later changes do not affect the latched access.
//  rst mid-ACCESS: store aborted (no write), response lost, state IDLE.
//  mem_adr holds the last latched address outside ACCESS; mem_write=0 outside ACCESS.
//  Address passed unmodified; the memory word-aligns it.
// CONFIGURATION
//  MISALIGN_CHECK_EN defined:
//   Adds ports if_err and d_err (out, 1), each pulsing together with its rvalid.
//   Latched addr[1:0]!=0 -> ACCESS cycle keeps mem_write=0; rdata not updated; err=1 in RESP.
//  MISALIGN_CHECK_EN undefined:
//   No err ports; addr[1:0] ignored, so the memory accesses the aligned-down word.
// STRUCTURE
//  Package mem_arb_pkg:
//   state enum {IDLE, ACCESS, RESP}; owner enum {OWN_IF, OWN_D};
//   ADDR_W/DATA_W defaults; reset value of last_served.
//  One sub-module, rr_arb2: two-way round-robin pick.
//   Inputs: req[1:0], last_served, enable. Output: one-hot grant. Purely combinational.
//  Top holds the FSM, request latch, rdata registers and memory drive.
// TESTING
//  1. Reset then if_req=1, if_addr=0x10, mem word 0x00A00093
//     -> if_gnt at cycle 0; if_rvalid at cycle 2; if_rdata=0x00A00093.
//  2. d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF
//     -> mem_write=1 for exactly one cycle; a load of 0x100 later returns 0xDEADBEEF.
//  3. if_req and d_req both held high from reset
//     -> grant order IF, D, IF, D; each owner gets rvalid 2 cycles after its gnt; no rvalid on the other side.
//  4. Store granted; rst pulsed during ACCESS
//     -> mem_write falls with rst; memory at that address unchanged; all outputs 0; next tie goes to IF.
//  5. Load granted, d_req dropped after gnt, d_addr changed to 0x200 during ACCESS
//     -> access uses the latched address; d_rvalid at cycle 2.
//  6. MISALIGN_CHECK_EN: d_we=1, d_addr=0x102
//     -> no mem_write; d_rvalid and d_err pulse together.
//     Without the macro -> word 0x100 is written.

Source files
------------

// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// mem_arb_pkg : shared types and defaults for the memory port arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Fetch wins the first tie after reset.
  localparam owner_t LAST_SERVED_RST = OWN_D;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// rr_arb2 : two-way round-robin pick; bit 0 = fetch, bit 1 = data
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_served,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (&req) begin
        grant = (last_served == OWN_D) ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter : shares one memory port between fetch and load/store.
// Optional MISALIGN_CHECK_EN adds if_err/d_err. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
`ifdef MISALIGN_CHECK_EN
  output logic              if_err,
  output logic              d_err,
`endif
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t            state, state_nx;
  owner_t            last_served, owner;
  logic [1:0]        grant;
  logic              lat_we, lat_mis, mis_in;
  logic [ADDR_W-1:0] lat_addr, sel_addr;
  logic [DATA_W-1:0] lat_wdata;

  rr_arb2 u_arb (
    .req         ({d_req, if_req}),
    .last_served (last_served),
    .enable      (state != ACCESS),
    .grant       (grant)
  );

  assign if_gnt   = grant[0] & ~rst;
  assign d_gnt    = grant[1] & ~rst;
  assign sel_addr = grant[1] ? d_addr : if_addr;

`ifdef MISALIGN_CHECK_EN
  assign mis_in = |sel_addr[1:0];
  assign if_err = if_rvalid & lat_mis;
  assign d_err  = d_rvalid & lat_mis;
`else
  assign mis_in = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_write = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (state)
      IDLE: begin
        if (|grant) state_nx = ACCESS;
      end
      ACCESS: begin
        mem_write = lat_we & ~lat_mis;
        state_nx  = RESP;
      end
      RESP: begin
        if_rvalid = (owner == OWN_IF);
        d_rvalid  = (owner == OWN_D);
        state_nx  = (|grant) ? ACCESS : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch: inputs matter only in the grant cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_served <= LAST_SERVED_RST;
      owner       <= OWN_IF;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_we      <= 1'b0;
      lat_mis     <= 1'b0;
    end else if (|grant) begin
      last_served <= grant[1] ? OWN_D : OWN_IF;
      owner       <= grant[1] ? OWN_D : OWN_IF;
      lat_addr    <= sel_addr;
      lat_wdata   <= grant[1] ? d_wdata : lat_wdata;
      lat_we      <= grant[1] & d_we;
      lat_mis     <= mis_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (state == ACCESS && !lat_we && !lat_mis) begin
      if (owner == OWN_D) begin
        d_rdata <= mem_read_data;
      end else begin
        if_rdata <= mem_read_data;
      end
    end
  end

  assign mem_adr        = lat_addr;
  assign mem_write_data = lat_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter : directed + random checks against a transaction model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_write;
  logic [31:0] if_rdata, d_rdata, mem_adr, mem_write_data, mem_read_data;
`ifdef MISALIGN_CHECK_EN
  logic        if_err, d_err;
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];

  assign mem_read_data = env_mem[mem_adr[9:2]];

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef MISALIGN_CHECK_EN
    .if_err(if_err), .d_err(d_err),
`endif
    .mem_adr(mem_adr), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;

  // Transaction model: at most one access outstanding, timed by cycle number.
  bit          p_valid = 0, p_d = 0, p_we = 0, p_mis = 0, last_d = 1;
  int          p_gc = 0;
  logic [31:0] p_addr = '0, p_wdata = '0, m_last_addr = '0;
  logic [31:0] exp_if_rd = '0, exp_d_rd = '0;
  bit          lg_if = 0, lg_d = 0;
  int          wr_cnt = 0, last_if_rv = -1, last_d_rv = -1;
  bit          glog[$];
  int          gcyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit e_acc, e_resp, g_if, g_d;
    lg_if = 0; lg_d = 0;
    if (rst) begin
      chk("rst_gnt", {30'd0, if_gnt, d_gnt}, 0);
      chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_mem_write", {31'd0, mem_write}, 0);
      chk("rst_mem_adr", mem_adr, 0);
      chk("rst_mem_wdata", mem_write_data, 0);
      p_valid = 0; last_d = 1; exp_if_rd = '0; exp_d_rd = '0; m_last_addr = '0;
      cyc++;
      return;
    end
    e_acc  = p_valid && (cyc == p_gc + 1);
    e_resp = p_valid && (cyc == p_gc + 2);
    if (e_acc && p_we && !p_mis) ref_mem[p_addr[9:2]] = p_wdata;
    if (e_resp && !p_we && !p_mis) begin
      if (p_d) exp_d_rd = ref_mem[p_addr[9:2]];
      else     exp_if_rd = ref_mem[p_addr[9:2]];
    end
    chk("mem_write", {31'd0, mem_write}, {31'd0, e_acc && p_we && !p_mis});
    chk("mem_adr", mem_adr, m_last_addr);
    if (e_acc && p_we) chk("mem_write_data", mem_write_data, p_wdata);
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, e_resp && !p_d});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, e_resp && p_d});
`ifdef MISALIGN_CHECK_EN
    chk("if_err", {31'd0, if_err}, {31'd0, e_resp && !p_d && p_mis});
    chk("d_err", {31'd0, d_err}, {31'd0, e_resp && p_d && p_mis});
`endif
    chk("if_rdata", if_rdata, exp_if_rd);
    chk("d_rdata", d_rdata, exp_d_rd);
    if (if_rvalid) last_if_rv = cyc;
    if (d_rvalid)  last_d_rv = cyc;
    if (mem_write) begin
      wr_cnt++;
      env_mem[mem_adr[9:2]] = mem_write_data;
    end
    if (e_resp) p_valid = 0;
    g_if = 0; g_d = 0;
    if (!e_acc) begin
      if (if_req && d_req) begin
        g_if = last_d; g_d = !last_d;
      end else begin
        g_if = if_req; g_d = d_req;
      end
    end
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, g_if});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, g_d});
    if (g_if || g_d) begin
      p_valid = 1; p_d = g_d; p_gc = cyc;
      p_addr  = g_d ? d_addr : if_addr;
      p_we    = g_d && d_we;
      p_wdata = d_wdata;
      p_mis   = MIS && (p_addr[1:0] != 2'b00);
      m_last_addr = p_addr;
      last_d  = g_d;
      glog.push_back(g_d);
      gcyc.push_back(cyc);
    end
    lg_if = g_if; lg_d = g_d;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 0; d_req = 0; d_we = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  bit if_pend = 0, d_pend = 0;
  int c0, gi;

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    env_mem[4]   = 32'h00A00093; ref_mem[4]   = 32'h00A00093;
    env_mem[192] = 32'h11111111; ref_mem[192] = 32'h11111111;

    // Single fetch after reset
    do_reset();
    c0 = cyc;
    if_req = 1; if_addr = 32'h10;
    tick();
    if_req = 0;
    tick(); tick();
    chk("t1_gnt_cycle", gcyc[gcyc.size()-1], c0);
    chk("t1_rv_latency", last_if_rv - c0, 2);
    chk("t1_if_rdata", if_rdata, 32'h00A00093);

    // Store then load back, with inputs disturbed after the grant
    gi = wr_cnt;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    tick();
    d_req = 0; d_we = 0; d_wdata = 32'h0;
    tick(); tick();
    chk("t2_single_write", wr_cnt - gi, 1);
    chk("t2_mem_word", env_mem[64], 32'hDEADBEEF);
    d_req = 1; d_we = 0; d_addr = 32'h100;
    tick();
    c0 = gcyc[gcyc.size()-1];
    d_req = 0;
    d_addr = 32'h200;
    tick(); tick();
    chk("t5_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("t5_rv_latency", last_d_rv - c0, 2);

    // Misaligned store, then read the aligned word
    d_req = 1; d_we = 1; d_addr = 32'h102; d_wdata = 32'h12345678;
    tick();
    d_req = 0; d_we = 0;
    tick(); tick();
    d_req = 1; d_addr = 32'h100;
    tick();
    d_req = 0;
    tick(); tick();
    chk("t6_d_rdata", d_rdata, MIS ? 32'hDEADBEEF : 32'h12345678);

    // Both requesters saturated from reset
    do_reset();
    glog.delete();
    if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h104;
    repeat (8) tick();
    if_req = 0; d_req = 0;
    tick(); tick();
    chk("t3_grant_count", glog.size(), 4);
    chk("t3_grant0", {31'd0, glog[0]}, 0);
    chk("t3_grant1", {31'd0, glog[1]}, 1);
    chk("t3_grant2", {31'd0, glog[2]}, 0);
    chk("t3_grant3", {31'd0, glog[3]}, 1);

    // Reset during a store's ACCESS cycle
    d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'hCAFEF00D;
    tick();
    d_req = 0; d_we = 0;
    chk("t4_write_before_rst", {31'd0, mem_write}, 1);
    rst = 1'b1;
    #1;
    chk("t4_write_drops", {31'd0, mem_write}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t4_mem_unchanged", env_mem[192], 32'h11111111);
    glog.delete();
    if_req = 1; if_addr = 32'h20; d_req = 1; d_addr = 32'h24;
    tick();
    if_req = 0; d_req = 0;
    tick(); tick();
    chk("t4_tie_to_if", {31'd0, glog[0]}, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (lg_if) if_pend = 0;
      if (lg_d)  d_pend = 0;
      if (!if_pend) begin
        if_addr = rand_addr();
        if ($urandom_range(0, 2) != 0) if_pend = 1;
      end
      if (!d_pend) begin
        d_addr  = rand_addr();
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
        if ($urandom_range(0, 2) != 0) d_pend = 1;
      end
      if_req = if_pend;
      d_req  = d_pend;
      tick();
    end
    if_req = 0; d_req = 0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
